// File: rtl/sl_rx_ctrl_pkg.sv
// Shared constants for the SL receiver host controller: status/config bit
// positions, register map, interrupt-enable bits and config FSM states.
package sl_rx_ctrl_pkg;

  localparam int ST_WLC = 0;
  localparam int ST_WRP = 1;
  localparam int ST_WRF = 3;
  localparam int ST_PEF = 4;
  localparam int ST_LEF = 5;

  localparam int CF_PCE = 0;
  localparam int CF_BQL = 1;
  localparam int CF_BQH = 6;

  localparam logic [1:0] ADDR_CFG   = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_STAT  = 2'd2;
  localparam logic [1:0] ADDR_IRQEN = 2'd3;

  localparam int IE_FIFO = 0;
  localparam int IE_CNT  = 1;
  localparam int IE_OVF  = 2;
  localparam int IE_CFG  = 3;

  typedef enum logic [1:0] {
    CFG_IDLE = 2'd0,
    CFG_REQ  = 2'd1,
    CFG_DONE = 2'd2
  } cfg_state_e;

  // The receiver only supports even bit quantities of at least 8.
  function automatic logic bq_ok(input logic [CF_BQH-CF_BQL:0] bq);
    return (bq >= 6'd8) && !bq[0];
  endfunction

endpackage

// File: rtl/sl_word_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module sl_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [3:0]       count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [3:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == 4'd0);
  assign full_o  = (count_q == 4'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + 4'(do_push) - 4'(do_pop);
    end
  end

endmodule

// File: rtl/sl_rx_ctrl.sv
// Host-side controller for one SL receiver: config handshake, word draining
// into a FIFO, saturating error counters and a level interrupt.
module sl_rx_ctrl
  import sl_rx_ctrl_pkg::*;
#(
  parameter int CONFIG_WIDTH = 16,
  parameter int STATUS_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CFG_TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              host_addr,
  input  logic                    host_wr,
  input  logic                    host_rd,
  input  logic [31:0]             host_wdata,
  output logic [31:0]             host_rdata,
  output logic                    irq,
  input  logic [STATUS_WIDTH-1:0] rx_status,
  input  logic [31:0]             rx_data,
  input  logic [CONFIG_WIDTH-1:0] rx_config,
  input  logic                    rx_changed,
  output logic [CONFIG_WIDTH-1:0] rx_wr_config,
  output logic                    rx_wr_enable,
  output logic                    rx_word_picked
);

  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CFG_TIMEOUT - 1);

  logic cfg_wr, stat_wr, irqen_wr, data_rd;
  assign cfg_wr   = host_wr && (host_addr == ADDR_CFG);
  assign stat_wr  = host_wr && (host_addr == ADDR_STAT);
  assign irqen_wr = host_wr && (host_addr == ADDR_IRQEN);
  assign data_rd  = host_rd && (host_addr == ADDR_DATA);

  logic unused_inputs;
  assign unused_inputs = ^{host_wdata, rx_status, rx_changed};

  // ---------------- config FSM ----------------
  cfg_state_e              state_q;
  logic [CONFIG_WIDTH-1:0] pend_cfg_q;
  logic                    wr_en_q;
  logic [TW-1:0]           tmo_q;
  logic                    cfg_err_q;
  logic                    cfg_done_q;
  logic                    cfg_busy;

  assign cfg_busy     = (state_q != CFG_IDLE);
  assign rx_wr_config = pend_cfg_q;
  assign rx_wr_enable = wr_en_q;

  // A STAT write clears the sticky flags and wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CFG_IDLE;
      pend_cfg_q <= '0;
      wr_en_q    <= 1'b0;
      tmo_q      <= '0;
      cfg_err_q  <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      if (stat_wr) begin
        cfg_err_q  <= 1'b0;
        cfg_done_q <= 1'b0;
      end
      case (state_q)
        CFG_IDLE: begin
          if (cfg_wr) begin
            pend_cfg_q <= host_wdata[CONFIG_WIDTH-1:0];
            if (bq_ok(host_wdata[CF_BQH:CF_BQL])) begin
              state_q <= CFG_REQ;
              wr_en_q <= 1'b1;
              tmo_q   <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        CFG_REQ: begin
          // Readback in the first enable cycle still reflects the old config.
          if ((tmo_q != '0) && (rx_config == pend_cfg_q)) begin
            state_q <= CFG_DONE;
            wr_en_q <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= CFG_IDLE;
            wr_en_q <= 1'b0;
            if (!stat_wr) cfg_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        CFG_DONE: begin
          state_q <= CFG_IDLE;
          if (!stat_wr) cfg_done_q <= 1'b1;
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

  // ---------------- word capture ----------------
  logic        wrf_q;
  logic        wrf_rise;
  logic        word_picked_q;
  logic        ovf_q;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic [3:0]  fifo_count;

  assign wrf_rise       = rx_status[ST_WRF] && !wrf_q;
  assign fifo_pop       = data_rd && !fifo_empty;
  assign rx_word_picked = word_picked_q;

  sl_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wrf_rise),
    .pop_i   (fifo_pop),
    .wdata_i (rx_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The word is acknowledged even when it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrf_q         <= 1'b0;
      word_picked_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      wrf_q         <= rx_status[ST_WRF];
      word_picked_q <= wrf_rise;
      if (stat_wr)                                    ovf_q <= 1'b0;
      else if (wrf_rise && fifo_full && !fifo_pop)    ovf_q <= 1'b1;
    end
  end

  // ---------------- error counters: 0 len, 1 par, 2 lev ----------------
  logic [2:0]      err_lvl;
  logic [2:0][7:0] err_cnt;

  assign err_lvl = {rx_status[ST_LEF], rx_status[ST_PEF], rx_status[ST_WLC]};

  for (genvar gi = 0; gi < 3; gi++) begin : g_err_cnt
    logic       lvl_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lvl_q <= 1'b0;
        cnt_q <= 8'd0;
      end else begin
        lvl_q <= err_lvl[gi];
        if (stat_wr)
          cnt_q <= 8'd0;
        else if (err_lvl[gi] && !lvl_q && (cnt_q != 8'hFF))
          cnt_q <= cnt_q + 8'd1;
      end
    end

    assign err_cnt[gi] = cnt_q;
  end

  // ---------------- registers, read path, interrupt ----------------
  logic [3:0]  irqen_q;
  logic [31:0] host_rdata_q;
  logic [31:0] rd_mux;
  logic        irq_q;
  logic [3:0]  irq_cause;
  logic        irq_d;

  always_comb begin
    rd_mux = '0;
    case (host_addr)
      ADDR_CFG:   rd_mux = {cfg_busy, cfg_err_q, cfg_done_q, 29'(rx_config)};
      ADDR_DATA:  rd_mux = fifo_empty ? 32'd0 : fifo_head;
      ADDR_STAT:  rd_mux = {err_cnt[2], err_cnt[0], err_cnt[1], ovf_q, 3'b000, fifo_count};
      ADDR_IRQEN: rd_mux = {28'd0, irqen_q};
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    irq_cause          = '0;
    irq_cause[IE_FIFO] = !fifo_empty;
    irq_cause[IE_CNT]  = |err_cnt;
    irq_cause[IE_OVF]  = ovf_q;
    irq_cause[IE_CFG]  = cfg_done_q || cfg_err_q;
  end

  assign irq_d      = |(irq_cause & irqen_q);
  assign irq        = irq_q;
  assign host_rdata = host_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqen_q      <= 4'd0;
      host_rdata_q <= 32'd0;
      irq_q        <= 1'b0;
    end else begin
      if (irqen_wr) irqen_q <= host_wdata[3:0];
      if (host_rd)  host_rdata_q <= rd_mux;
      irq_q <= irq_d;
    end
  end

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Self-checking bench for sl_rx_ctrl: config pre-check table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_sl_rx_ctrl;

  localparam logic [1:0] A_CFG   = 2'd0;
  localparam logic [1:0] A_DATA  = 2'd1;
  localparam logic [1:0] A_STAT  = 2'd2;
  localparam logic [1:0] A_IRQEN = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  host_addr = 2'd0;
  logic        host_wr = 1'b0;
  logic        host_rd = 1'b0;
  logic [31:0] host_wdata = 32'd0;
  logic [31:0] host_rdata;
  logic        irq;
  logic [15:0] rx_status = 16'd0;
  logic [31:0] rx_data = 32'd0;
  logic [15:0] rx_config = 16'd0;
  logic        rx_changed = 1'b0;
  logic [15:0] rx_wr_config;
  logic        rx_wr_enable;
  logic        rx_word_picked;

  int tests = 0;
  int fails = 0;

  sl_rx_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_addr      (host_addr),
    .host_wr        (host_wr),
    .host_rd        (host_rd),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata),
    .irq            (irq),
    .rx_status      (rx_status),
    .rx_data        (rx_data),
    .rx_config      (rx_config),
    .rx_changed     (rx_changed),
    .rx_wr_config   (rx_wr_config),
    .rx_wr_enable   (rx_wr_enable),
    .rx_word_picked (rx_word_picked)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    host_addr  = a;
    host_wdata = d;
    host_wr    = 1'b1;
    tick();
    host_wr = 1'b0;
    $display("[TB] wr addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    host_addr = a;
    host_rd   = 1'b1;
    tick();
    host_rd = 1'b0;
    d = host_rdata;
    $display("[TB] rd addr=%0d data=%h", a, d);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(name, d, exp);
  endtask

  // Behavioural model: FIFO as a queue, counters as saturating integers.
  logic [31:0] mq[$];
  int          m_len = 0;
  int          m_par = 0;
  int          m_lev = 0;
  bit          m_ovf = 1'b0;
  bit [3:0]    m_ien = 4'd0;
  bit [5:0]    m_prev = 6'd0;

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_step(output logic [31:0] e_rd, output logic e_irq, output logic e_pick);
    logic [3:0] cause;
    bit         rise;
    cause = {1'b0, m_ovf, (m_len + m_par + m_lev) != 0, mq.size() != 0};
    e_irq = |(cause & m_ien);
    e_rd  = 32'd0;
    case (host_addr)
      A_DATA:  if (mq.size() > 0) e_rd = mq[0];
      A_STAT:  e_rd = {m_lev[7:0], m_len[7:0], m_par[7:0], m_ovf, 3'b000, 4'(mq.size())};
      A_IRQEN: e_rd = {28'd0, m_ien};
      default: e_rd = 32'd0;
    endcase
    if (host_rd && host_addr == A_DATA && mq.size() > 0) void'(mq.pop_front());
    rise   = rx_status[3] && !m_prev[3];
    e_pick = rise;
    if (rise) begin
      if (mq.size() < 4) mq.push_back(rx_data);
      else m_ovf = 1'b1;
    end
    if (rx_status[0] && !m_prev[0]) m_len = sat_inc(m_len);
    if (rx_status[4] && !m_prev[4]) m_par = sat_inc(m_par);
    if (rx_status[5] && !m_prev[5]) m_lev = sat_inc(m_lev);
    if (host_wr && host_addr == A_STAT) begin
      m_len = 0;
      m_par = 0;
      m_lev = 0;
      m_ovf = 1'b0;
    end
    if (host_wr && host_addr == A_IRQEN) m_ien = host_wdata[3:0];
    m_prev = rx_status[5:0];
  endtask

  typedef struct {
    logic [31:0] wdata;
    logic        exp_en;
    logic        exp_err;
    logic        exp_done;
  } cfg_vec_t;

  cfg_vec_t cv[9];

  initial begin
    logic        any_en;
    logic [31:0] d;
    logic [31:0] e_rd;
    logic        e_irq;
    logic        e_pick;
    int          n;

    cv[0] = '{32'h0000_000E, 1'b0, 1'b1, 1'b0};
    cv[1] = '{32'h0000_0010, 1'b1, 1'b0, 1'b1};
    cv[2] = '{32'h0000_0012, 1'b0, 1'b1, 1'b0};
    cv[3] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0};
    cv[4] = '{32'h0000_007E, 1'b0, 1'b1, 1'b0};
    cv[5] = '{32'h0000_007C, 1'b1, 1'b0, 1'b1};
    cv[6] = '{32'h0000_0011, 1'b1, 1'b0, 1'b1};
    cv[7] = '{32'hABCD_FF90, 1'b1, 1'b0, 1'b1};
    cv[8] = '{32'h0000_000C, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_rdata", host_rdata, 32'd0);
    chk_b("rst_irq", irq, 1'b0);
    chk_b("rst_wr_en", rx_wr_enable, 1'b0);
    chk_b("rst_picked", rx_word_picked, 1'b0);
    chk("rst_wr_cfg", {16'd0, rx_wr_config}, 32'd0);
    rd_chk("rst_stat", A_STAT, 32'd0);
    rd_chk("rst_cfg", A_CFG, 32'd0);
    rd_chk("rst_irqen", A_IRQEN, 32'd0);
    rd_chk("rst_data", A_DATA, 32'd0);

    // Config pre-check table
    for (int i = 0; i < 9; i++) begin
      bus_write(A_STAT, 32'd0);
      rx_config = cv[i].wdata[15:0];
      any_en = 1'b0;
      bus_write(A_CFG, cv[i].wdata);
      for (int k = 0; k < 5; k++) begin
        any_en = any_en | rx_wr_enable;
        tick();
      end
      chk_b("cfg_tab_en", any_en, cv[i].exp_en);
      rd_chk("cfg_tab_flags", A_CFG,
             {1'b0, cv[i].exp_err, cv[i].exp_done, 13'd0, cv[i].wdata[15:0]});
    end

    // Config accepted after a 3-cycle enable
    bus_write(A_STAT, 32'd0);
    rx_config = 16'h0000;
    bus_write(A_CFG, 32'h0000_0010);
    chk_b("acc_en1", rx_wr_enable, 1'b1);
    chk("acc_wr_cfg", {16'd0, rx_wr_config}, 32'h0000_0010);
    tick();
    chk_b("acc_en2", rx_wr_enable, 1'b1);
    tick();
    chk_b("acc_en3", rx_wr_enable, 1'b1);
    rx_config = 16'h0010;
    tick();
    chk_b("acc_en_off", rx_wr_enable, 1'b0);
    rd_chk("acc_busy", A_CFG, 32'h8000_0010);
    rd_chk("acc_done", A_CFG, 32'h2000_0010);

    // Valid config never matched times out; a CFG write mid-REQ is ignored
    bus_write(A_STAT, 32'd0);
    bus_write(A_CFG, 32'h0000_0020);
    n = 0;
    while (rx_wr_enable && n < 400) begin
      n++;
      if (n == 2) begin
        host_addr  = A_CFG;
        host_wdata = 32'h0000_0030;
        host_wr    = 1'b1;
      end
      tick();
      host_wr = 1'b0;
    end
    chk("tmo_cycles", 32'(n), 32'd255);
    chk("tmo_wr_cfg", {16'd0, rx_wr_config}, 32'h0000_0020);
    rd_chk("tmo_flags", A_CFG, 32'h4000_0010);
    bus_write(A_STAT, 32'd0);

    // Single word flow
    rx_data = 32'hA5A5_0F0F;
    rx_status[3] = 1'b1;
    tick();
    chk_b("wf_picked", rx_word_picked, 1'b1);
    rd_chk("wf_count1", A_STAT, 32'h0000_0001);
    chk_b("wf_picked_once", rx_word_picked, 1'b0);
    rx_status[3] = 1'b0;
    rd_chk("wf_data", A_DATA, 32'hA5A5_0F0F);
    rd_chk("wf_count0", A_STAT, 32'd0);

    // Overflow: 5 pushes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      rx_data = 32'h1000_0000 + 32'(i);
      rx_status[3] = 1'b1;
      tick();
      rx_status[3] = 1'b0;
      tick();
    end
    rd_chk("ovf_stat", A_STAT, 32'h0000_0084);
    for (int i = 0; i < 4; i++) rd_chk("ovf_order", A_DATA, 32'h1000_0000 + 32'(i));
    rd_chk("ovf_empty_rd", A_DATA, 32'd0);
    rd_chk("ovf_sticky", A_STAT, 32'h0000_0080);
    bus_write(A_STAT, 32'd0);

    // Counter saturation and clear priority
    for (int i = 0; i < 300; i++) begin
      rx_status[0] = 1'b1;
      tick();
      rx_status[0] = 1'b0;
      tick();
    end
    rd_chk("sat_len", A_STAT, 32'h00FF_0000);
    bus_write(A_STAT, 32'd0);
    rd_chk("sat_clear", A_STAT, 32'd0);
    rx_status[0] = 1'b1;
    bus_write(A_STAT, 32'd0);
    rd_chk("clr_wins", A_STAT, 32'd0);
    rx_status[4] = 1'b1;
    tick();
    rd_chk("par_pos", A_STAT, 32'h0000_0100);
    rx_status[5] = 1'b1;
    tick();
    rd_chk("lev_pos", A_STAT, 32'h0100_0100);
    rx_status = 16'd0;
    bus_write(A_STAT, 32'd0);

    // IRQ on FIFO non-empty
    bus_write(A_IRQEN, 32'h0000_0001);
    tick();
    tick();
    chk_b("irq_empty", irq, 1'b0);
    rd_chk("irqen_rb", A_IRQEN, 32'h0000_0001);
    rx_data = 32'hCAFE_0001;
    rx_status[3] = 1'b1;
    tick();
    chk_b("irq_p1", irq, 1'b0);
    rx_status[3] = 1'b0;
    tick();
    chk_b("irq_p2", irq, 1'b1);
    bus_read(A_DATA, d);
    chk("irq_data", d, 32'hCAFE_0001);
    chk_b("irq_pop1", irq, 1'b1);
    tick();
    chk_b("irq_pop2", irq, 1'b0);
    bus_write(A_IRQEN, 32'd0);

    // Asynchronous reset in REQ drops the enable, no retry afterwards
    bus_write(A_STAT, 32'd0);
    rx_config = 16'h0000;
    bus_write(A_CFG, 32'h0000_0010);
    tick();
    chk_b("arst_req", rx_wr_enable, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_b("arst_drop", rx_wr_enable, 1'b0);
    #3 rst_n = 1'b1;
    any_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      any_en = any_en | rx_wr_enable;
    end
    chk_b("arst_no_retry", any_en, 1'b0);
    chk("arst_wr_cfg", {16'd0, rx_wr_config}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int op;
      if ($urandom_range(0, 1) == 0) rx_status[3] = ~rx_status[3];
      if ($urandom_range(0, 3) == 0) rx_status[0] = ~rx_status[0];
      if ($urandom_range(0, 3) == 0) rx_status[4] = ~rx_status[4];
      if ($urandom_range(0, 3) == 0) rx_status[5] = ~rx_status[5];
      rx_data = $urandom;
      host_rd = 1'b0;
      host_wr = 1'b0;
      op = $urandom_range(0, 15);
      case (op)
        0, 1, 2, 3: begin host_addr = A_DATA;  host_rd = 1'b1; end
        4:          begin host_addr = A_STAT;  host_rd = 1'b1; end
        5:          begin host_addr = A_STAT;  host_wr = 1'b1; host_wdata = $urandom; end
        6:          begin host_addr = A_IRQEN; host_wr = 1'b1; host_wdata = 32'($urandom_range(0, 15)); end
        7:          begin host_addr = A_IRQEN; host_rd = 1'b1; end
        default:    host_addr = 2'($urandom_range(0, 3));
      endcase
      model_step(e_rd, e_irq, e_pick);
      tick();
      chk_b("rnd_picked", rx_word_picked, e_pick);
      chk_b("rnd_irq", irq, e_irq);
      if (host_rd) begin
        $display("[TB] rnd rd addr=%0d data=%h", host_addr, host_rdata);
        chk("rnd_rdata", host_rdata, e_rd);
      end else if (host_wr) begin
        $display("[TB] rnd wr addr=%0d data=%h", host_addr, host_wdata);
      end
      host_rd = 1'b0;
      host_wr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sl_rx_ctrl.md
# sl_rx_ctrl

Host-side controller for the serial-line (SL) receiver. It sequences configuration writes into the receiver and confirms that each one has taken effect. It drains completed words into a small FIFO while acknowledging them with `word_picked`, and it keeps saturating error counters. It also raises a level interrupt. It sits between a simple single-cycle register bus and one receiver instance.

## Interface
Parameters:
- `CONFIG_WIDTH`, 16: receiver config width.
- `STATUS_WIDTH`, 16: receiver status width.
- `FIFO_DEPTH`, 4: word FIFO depth; must be a power of 2, maximum 8.
- `CFG_TIMEOUT`, 255: maximum number of cycles to wait for the receiver to accept a config.

Ports:
- Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.
- `clk`, in, 1: 16 MHz system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `host_addr`, in, 2: register select (0 CFG, 1 DATA, 2 STAT, 3 IRQEN).
- `host_wr`, in, 1: write strobe, one cycle.
- `host_rd`, in, 1: read strobe, one cycle.
- `host_wdata`, in, 32: write data.
- `host_rdata`, out, 32: registered read data.
- `irq`, out, 1: level interrupt.
- `rx_status`, in, STATUS_WIDTH: receiver status. Bit positions are WLC=0, WRP=1, WRF=3, PEF=4, LEF=5.
- `rx_data`, in, 32: receiver buffered word.
- `rx_config`, in, CONFIG_WIDTH: receiver current config readback.
- `rx_changed`, in, 1: receiver data/status-changed pulse.
- `rx_wr_config`, out, CONFIG_WIDTH: config presented to the receiver.
- `rx_wr_enable`, out, 1: config write enable.
- `rx_word_picked`, out, 1: acknowledges the word and clears the receiver's WRF.

## Operation
Config FSM, states IDLE, REQ, DONE:
- A host write to CFG in IDLE latches `host_wdata[CONFIG_WIDTH-1:0]` into `pend_cfg`.
- Pre-check: if the bit-quantity field [6:1] is less than 8 or is odd, set `cfg_err` and stay in IDLE. `rx_wr_enable` is never asserted in this case.
- If the pre-check passes, go to REQ.
- REQ: drive `rx_wr_config`=`pend_cfg` and `rx_wr_enable`=1, and count cycles.
  - When `rx_config` == `pend_cfg`, go to DONE.
  - When the count reaches `CFG_TIMEOUT`, set `cfg_err` and go to IDLE.
- DONE: set the `cfg_done` sticky flag and go to IDLE after one cycle.
- A CFG write while the FSM is not in IDLE is ignored.

Word capture:
- `wrf_q` holds `rx_status[WRF]` delayed by one cycle.
- When WRF rises, push `rx_data` into the FIFO and pulse `rx_word_picked` for one cycle.
- If the FIFO is full, drop the word, set `ovf`, and pulse `rx_word_picked` anyway.

Error counters:
- Three 8-bit counters: `len_cnt`, `par_cnt`, `lev_cnt`.
- Each increments on the rising edge of WLC, PEF, or LEF respectively.
- Counters saturate at 255.

Registers:
- CFG:
  - Read returns {`cfg_busy`, `cfg_err`, `cfg_done`, 13'b0, `rx_config`}.
  - Write behaves as described in the config FSM above.
- DATA:
  - Read returns the FIFO head and pops it.
  - If the FIFO is empty, the read returns 0 and does not pop.
- STAT:
  - Read returns {`lev_cnt`, `len_cnt`, `par_cnt`, `ovf`, 3'b0, `fifo_count[3:0]`}.
  - Write (any value) clears the three counters, `ovf`, `cfg_err`, and `cfg_done`.
- IRQEN:
  - Read/write of bits [3:0]: [0] FIFO non-empty, [1] any counter non-zero, [2] `ovf`, [3] `cfg_done` or `cfg_err`.
- `irq` = OR of each enabled cause bit ANDed with its cause.

## Timing
- Reset values: `host_rdata`=0, `irq`=0, `rx_wr_enable`=0, `rx_word_picked`=0, `rx_wr_config`=0, FIFO empty, counters 0, all flags 0, IRQEN=0, config FSM in IDLE.
- Read latency is 1 cycle: `host_rdata` is valid in the cycle after `host_rd`. A DATA pop takes effect on the same edge.
- `rx_word_picked` is asserted in the cycle after the WRF rise is sampled.
- Push latency is 1 cycle: the word is readable in the second cycle after the WRF rise.
- Simultaneous push and pop: both happen and the count is unchanged. A push into a full FIFO in the same cycle as a pop is accepted, with no `ovf`.
- Counter increment coinciding with a STAT clear: the clear wins.
- `cfg_busy` is 1 in REQ and DONE.
- A config match is detected in REQ no earlier than one cycle after `rx_wr_enable` rises.
- `irq` is registered and follows its causes by 1 cycle.
- An asynchronous reset mid-REQ drops `rx_wr_enable` immediately. No config retry follows reset.

## Structure
- Shared package holds:
  - status bit indices (WLC, WRP, WRF, PEF, LEF);
  - config field indices (PCE, BQL, BQH);
  - register address constants;
  - IRQEN bit indices.
- One sub-module, `sl_word_fifo`: synchronous FIFO with parameterised depth, push/pop/full/empty/count, and same-cycle push+pop support.

## Test plan
- Config accepted: write CFG=0x0010 with `rx_config` matching 3 cycles later. Expect `rx_wr_enable` high for 3 cycles, then `cfg_done`=1 and `cfg_busy`=0.
- Config rejected: write CFG with bit quantity 7 (0x000E). Expect `cfg_err`=1 with `rx_wr_enable` never asserted. Separately, a valid config never matched sets `cfg_err` after 255 cycles.
- Word flow: raise WRF with `rx_data`=0xA5A5_0F0F. Expect a one-cycle `rx_word_picked`, FIFO count 1, and a DATA read returning 0xA5A5_0F0F, after which the count is 0.
- Overflow: push 5 words with no reads at FIFO depth 4. Expect `ovf`=1, count=4, and the 4 oldest words read back in order.
- Errors and saturation: deliver 300 WLC rising edges. Expect `len_cnt`=255. A STAT write clears it to 0. A simultaneous increment and clear gives 0.
- IRQ: IRQEN=0x1 with an empty FIFO keeps `irq`=0. Push one word and `irq`=1 one cycle later. Read DATA and `irq` returns to 0.
